vib_excursion_alarm_mc: RTL and testbench

//  Parametrised multi-channel vibration alarm. Successor to the fixed 4-channel baseline/alarm pair.
//  Per channel: takes |sample - baseline| and compares it to a shared threshold with hysteresis.

---
 rtl/vib_excursion_alarm_mc.sv | 158 +++++++++++++++
 tb/tb_vib_excursion_alarm_mc.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vib_excursion_alarm_mc.sv
// Multi-channel vibration excursion alarm.
// Each lane takes |sample - baseline|, compares it against a shared threshold
// with release hysteresis, debounces over N consecutive samples and drives a
// per-channel alarm, optionally latched until alarm_clr.

module vib_exc_lane #(
  parameter int DW    = 16,
  parameter int CNT_W = 8,
  parameter int LATCH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    dat,
  input  logic             dat_en,
  input  logic [DW-1:0]    base_line,
  input  logic [DW-1:0]    thresh,
  input  logic [DW-1:0]    hyst,
  input  logic [CNT_W-1:0] debounce_n,
  input  logic             alarm_clr,
  output logic [DW-1:0]    exc,
  output logic             exc_en,
  output logic             alarm
);

  localparam bit LATCH_EN = (LATCH != 0);

  typedef enum logic {IDLE = 1'b0, ALARM = 1'b1} state_t;

  state_t           st;
  logic [DW-1:0]    mag;
  logic [DW:0]      exc_hyst;
  logic             over, under, hit;
  logic [CNT_W-1:0] cnt, cnt_sat, n_eff;
  logic [CNT_W:0]   cnt_p1;

  // Stage-1 magnitude; ordering the operands keeps it unsigned with no wrap.
  always_comb begin
    mag = (dat >= base_line) ? (dat - base_line) : (base_line - dat);
  end

  // Stage 1: capture excursion on strobe, hold it between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc    <= '0;
      exc_en <= 1'b0;
    end else begin
      exc_en <= dat_en;
      if (dat_en) exc <= mag;
    end
  end

  // Stage-2 qualifiers; hysteresis sum is one bit wider so it cannot wrap.
  always_comb begin
    exc_hyst = {1'b0, exc} + {1'b0, hyst};
    over     = exc > thresh;
    under    = exc_hyst < {1'b0, thresh};
    n_eff    = (debounce_n == '0) ? CNT_W'(1) : debounce_n;
    cnt_p1   = {1'b0, cnt} + (CNT_W+1)'(1);
    hit      = cnt_p1 == {1'b0, n_eff};
    cnt_sat  = (&cnt) ? cnt : cnt_p1[CNT_W-1:0];
  end

  // Stage 2: debounce FSM; clear has priority over a same-cycle sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      cnt   <= '0;
      alarm <= 1'b0;
    end else if (LATCH_EN && alarm_clr) begin
      st    <= IDLE;
      cnt   <= '0;
      alarm <= 1'b0;
    end else if (exc_en) begin
      case (st)
        IDLE: begin
          if (over) begin
            if (hit) begin
              st    <= ALARM;
              cnt   <= '0;
              alarm <= 1'b1;
            end else begin
              cnt <= cnt_sat;
            end
          end else begin
            cnt <= '0;
          end
        end
        ALARM: begin
          if (!LATCH_EN) begin
            if (under) begin
              if (hit) begin
                st    <= IDLE;
                cnt   <= '0;
                alarm <= 1'b0;
              end else begin
                cnt <= cnt_sat;
              end
            end else begin
              cnt <= '0;
            end
          end
        end
        default: begin
          st    <= IDLE;
          cnt   <= '0;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule

module vib_excursion_alarm_mc #(
  parameter int NCH   = 4,
  parameter int DW    = 16,
  parameter int CNT_W = 8,
  parameter int LATCH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] dat,
  input  logic [NCH-1:0]    dat_en,
  input  logic [NCH*DW-1:0] base_line,
  input  logic [DW-1:0]     thresh,
  input  logic [DW-1:0]     hyst,
  input  logic [CNT_W-1:0]  debounce_n,
  input  logic              alarm_clr,
  output logic [NCH*DW-1:0] exc,
  output logic [NCH-1:0]    exc_en,
  output logic [NCH-1:0]    alarm,
  output logic              alarm_any
);

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    vib_exc_lane #(.DW(DW), .CNT_W(CNT_W), .LATCH(LATCH)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .dat        (dat[g*DW +: DW]),
      .dat_en     (dat_en[g]),
      .base_line  (base_line[g*DW +: DW]),
      .thresh     (thresh),
      .hyst       (hyst),
      .debounce_n (debounce_n),
      .alarm_clr  (alarm_clr),
      .exc        (exc[g*DW +: DW]),
      .exc_en     (exc_en[g]),
      .alarm      (alarm[g])
    );
  end

  // Summary alarm, registered one cycle behind the per-channel alarms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm_any <= 1'b0;
    else     alarm_any <= |alarm;
  end

endmodule

// File: tb/tb_vib_excursion_alarm_mc.sv
// Bench for vib_excursion_alarm_mc: a self-releasing instance (LATCH=0) and a
// latching instance (LATCH=1) share all stimulus; a rule-level per-channel
// model predicts excursions and alarms for both.

module tb_vib_excursion_alarm_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] dat, base_line;
  logic [3:0]  dat_en;
  logic [15:0] thresh, hyst;
  logic [7:0]  dbn;
  logic        clr;

  logic [63:0] exc0, exc1;
  logic [3:0]  exc_en0, exc_en1, al0, al1;
  logic        any0, any1;

  int errors = 0;
  int checks = 0;

  // model state: [instance] -> per-channel alarm bits / debounce counts
  bit [3:0] m_al [2];
  int       m_cnt [2][4];
  int       exp_exc [4];

  always #5 clk = ~clk;

  vib_excursion_alarm_mc #(.NCH(4), .DW(16), .CNT_W(8), .LATCH(0)) u_dut0 (
    .clk(clk), .rst(rst), .dat(dat), .dat_en(dat_en), .base_line(base_line),
    .thresh(thresh), .hyst(hyst), .debounce_n(dbn), .alarm_clr(clr),
    .exc(exc0), .exc_en(exc_en0), .alarm(al0), .alarm_any(any0));

  vib_excursion_alarm_mc #(.NCH(4), .DW(16), .CNT_W(8), .LATCH(1)) u_dut1 (
    .clk(clk), .rst(rst), .dat(dat), .dat_en(dat_en), .base_line(base_line),
    .thresh(thresh), .hyst(hyst), .debounce_n(dbn), .alarm_clr(clr),
    .exc(exc1), .exc_en(exc_en1), .alarm(al1), .alarm_any(any1));

  function automatic int magn(int ch);
    int d;
    d = int'(dat[ch*16 +: 16]) - int'(base_line[ch*16 +: 16]);
    return (d < 0) ? -d : d;
  endfunction

  // One evaluated sample for instance L, channel ch, magnitude e.
  function automatic void mdl_sample(int L, int ch, int e);
    int n;
    n = (dbn == 0) ? 1 : int'(dbn);
    if (!m_al[L][ch]) begin
      if (e > int'(thresh)) begin
        if (m_cnt[L][ch] + 1 == n) begin m_al[L][ch] = 1'b1; m_cnt[L][ch] = 0; end
        else if (m_cnt[L][ch] < 255) m_cnt[L][ch]++;
      end else m_cnt[L][ch] = 0;
    end else if (L == 0) begin
      if (e + int'(hyst) < int'(thresh)) begin
        if (m_cnt[L][ch] + 1 == n) begin m_al[L][ch] = 1'b0; m_cnt[L][ch] = 0; end
        else if (m_cnt[L][ch] < 255) m_cnt[L][ch]++;
      end else m_cnt[L][ch] = 0;
    end
  endfunction

  function automatic void mdl_clear();
    m_al[1] = '0;
    for (int ch = 0; ch < 4; ch++) m_cnt[1][ch] = 0;
  endfunction

  function automatic void mdl_reset();
    for (int L = 0; L < 2; L++) begin
      m_al[L] = '0;
      for (int ch = 0; ch < 4; ch++) m_cnt[L][ch] = 0;
    end
    for (int ch = 0; ch < 4; ch++) exp_exc[ch] = 0;
  endfunction

  function automatic void set_dat(int ch, int v);
    dat[ch*16 +: 16] = 16'(v);
  endfunction

  // Strobe mask for one cycle; returns just after the capturing edge, or one
  // edge later when a clear is placed on the sample's evaluation cycle.
  task automatic pulse(input logic [3:0] mask, input bit with_clr);
    @(negedge clk);
    dat_en = mask;
    for (int ch = 0; ch < 4; ch++) begin
      if (mask[ch]) begin
        exp_exc[ch] = magn(ch);
        mdl_sample(0, ch, exp_exc[ch]);
        if (!with_clr) mdl_sample(1, ch, exp_exc[ch]);
      end
    end
    @(negedge clk);
    dat_en = '0;
    if (with_clr) begin
      clr = 1'b1;
      mdl_clear();
      @(negedge clk);
      clr = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; dat_en = '0; clr = 1'b0;
    thresh = 16'd100; hyst = 16'd20; dbn = 8'd3;
    for (int ch = 0; ch < 4; ch++) begin
      base_line[ch*16 +: 16] = 16'd1000;
      set_dat(ch, 1000);
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; dat_en = '0; clr = 1'b0; dat = '0; base_line = '0;
    thresh = 16'd100; hyst = 16'd20; dbn = 8'd3;
    repeat (2) @(negedge clk);
    checks++;
    if ({exc0, exc1} !== '0) begin errors++; $display("FAIL reset_exc got %h exp 0", {exc0, exc1}); end
    checks++;
    if ({exc_en0, exc_en1, al0, al1, any0, any1} !== '0)
      begin errors++; $display("FAIL reset_flags got %b exp 0", {exc_en0, exc_en1, al0, al1, any0, any1}); end
    do_reset();
  endtask

  task automatic test_debounce_rise();
    do_reset();
    set_dat(0, 1150);
    pulse(4'b0001, 1'b0);
    pulse(4'b0001, 1'b0);
    @(negedge clk);
    checks++;
    if (al0[0] !== 1'b0) begin errors++; $display("FAIL rise_after2 got %b exp 0", al0[0]); end
    pulse(4'b0001, 1'b0);
    checks++;
    if (exc0[15:0] !== 16'd150 || exc_en0[0] !== 1'b1 || exc_en1[0] !== 1'b1)
      begin errors++; $display("FAIL rise_exc got %0d/%b exp 150/1", exc0[15:0], exc_en0[0]); end
    checks++;
    if (al0[0] !== 1'b0) begin errors++; $display("FAIL rise_t1 got %b exp 0", al0[0]); end
    @(negedge clk);
    checks++;
    if (al0[0] !== 1'b1 || al1[0] !== 1'b1 || any0 !== 1'b0)
      begin errors++; $display("FAIL rise_t2 got %b%b%b exp 110", al0[0], al1[0], any0); end
    checks++;
    if (exc_en0[0] !== 1'b0 || exc0[15:0] !== 16'd150)
      begin errors++; $display("FAIL exc_hold got %b/%0d exp 0/150", exc_en0[0], exc0[15:0]); end
    @(negedge clk);
    checks++;
    if (any0 !== 1'b1 || any1 !== 1'b1) begin errors++; $display("FAIL any_t3 got %b%b exp 11", any0, any1); end
  endtask

  task automatic test_below_base();
    do_reset();
    set_dat(1, 850);
    repeat (3) pulse(4'b0010, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (exc0[31:16] !== 16'(exp_exc[1])) begin errors++; $display("FAIL below_exc got %0d exp %0d", exc0[31:16], exp_exc[1]); end
    checks++;
    if (al0 !== m_al[0] || al1 !== m_al[1] || al0 !== 4'b0010)
      begin errors++; $display("FAIL below_alarm got %b/%b exp %b/%b", al0, al1, m_al[0], m_al[1]); end
  endtask

  task automatic test_release();
    do_reset();
    set_dat(0, 1150);
    repeat (3) pulse(4'b0001, 1'b0);
    set_dat(0, 1090);
    repeat (5) pulse(4'b0001, 1'b0);
    @(negedge clk);
    checks++;
    if (al0[0] !== 1'b1) begin errors++; $display("FAIL hold_1090 got %b exp 1", al0[0]); end
    set_dat(0, 1070);
    repeat (2) pulse(4'b0001, 1'b0);
    @(negedge clk);
    checks++;
    if (al0[0] !== 1'b1) begin errors++; $display("FAIL hold_2nd_under got %b exp 1", al0[0]); end
    pulse(4'b0001, 1'b0);
    checks++;
    if (al0[0] !== 1'b1) begin errors++; $display("FAIL rel_t1 got %b exp 1", al0[0]); end
    @(negedge clk);
    checks++;
    if (al0[0] !== m_al[0][0] || al1[0] !== m_al[1][0] || al0[0] !== 1'b0)
      begin errors++; $display("FAIL rel_t2 got %b%b exp %b%b", al0[0], al1[0], m_al[0][0], m_al[1][0]); end
  endtask

  task automatic test_no_alarm_break();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_dat(0, (k == 2) ? 1000 : 1150);
      pulse(4'b0001, 1'b0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (al0 !== 4'b0000 || al1 !== 4'b0000) begin errors++; $display("FAIL break_seq got %b/%b exp 0", al0, al1); end
    do_reset();
    dbn = 8'd0;
    set_dat(0, 1150);
    pulse(4'b0001, 1'b0);
    @(negedge clk);
    checks++;
    if (al0[0] !== m_al[0][0] || al0[0] !== 1'b1) begin errors++; $display("FAIL dbn0 got %b exp 1", al0[0]); end
  endtask

  task automatic test_latch();
    do_reset();
    set_dat(2, 1150);
    repeat (3) pulse(4'b0100, 1'b0);
    set_dat(2, 1000);
    repeat (10) pulse(4'b0100, 1'b0);
    @(negedge clk);
    checks++;
    if (al0[2] !== 1'b0 || al1[2] !== 1'b1) begin errors++; $display("FAIL latch_hold got %b%b exp 01", al0[2], al1[2]); end
    @(negedge clk);
    clr = 1'b1;
    mdl_clear();
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (al1[2] !== 1'b0) begin errors++; $display("FAIL latch_clr got %b exp 0", al1[2]); end
    set_dat(2, 1150);
    repeat (2) pulse(4'b0100, 1'b0);
    pulse(4'b0100, 1'b1);
    @(negedge clk);
    checks++;
    if (al0[2] !== 1'b1 || al1[2] !== 1'b0 || al1 !== m_al[1])
      begin errors++; $display("FAIL clr_coinc got %b%b exp 10", al0[2], al1[2]); end
    repeat (2) pulse(4'b0100, 1'b0);
    @(negedge clk);
    checks++;
    if (al1[2] !== 1'b0) begin errors++; $display("FAIL clr_fresh2 got %b exp 0", al1[2]); end
    pulse(4'b0100, 1'b0);
    @(negedge clk);
    checks++;
    if (al1[2] !== 1'b1 || al1 !== m_al[1]) begin errors++; $display("FAIL clr_fresh3 got %b exp 1", al1[2]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < 4; ch++) set_dat(ch, 1101 + 10 * k + ch);
      dat_en = 4'hF;
      for (int ch = 0; ch < 4; ch++) begin
        exp_exc[ch] = magn(ch);
        mdl_sample(0, ch, exp_exc[ch]);
        mdl_sample(1, ch, exp_exc[ch]);
      end
      @(negedge clk);
    end
    dat_en = '0;
    checks++;
    if (al0 !== 4'h0) begin errors++; $display("FAIL b2b_t1 got %b exp 0000", al0); end
    for (int ch = 0; ch < 4; ch++) begin
      checks++;
      if (exc0[ch*16 +: 16] !== 16'(exp_exc[ch]))
        begin errors++; $display("FAIL b2b_exc ch%0d got %0d exp %0d", ch, exc0[ch*16 +: 16], exp_exc[ch]); end
    end
    @(negedge clk);
    checks++;
    if (al0 !== m_al[0] || al1 !== m_al[1] || al0 !== 4'hF)
      begin errors++; $display("FAIL b2b_t2 got %b/%b exp 1111", al0, al1); end
  endtask

  task automatic test_wide_and_reset();
    do_reset();
    base_line[15:0] = 16'h0000;  set_dat(0, 16'hFFFF);
    base_line[31:16] = 16'hFFFF; set_dat(1, 0);
    set_dat(2, 1101);
    base_line[63:48] = 16'd500;  set_dat(3, 500);
    repeat (3) pulse(4'hF, 1'b0);
    for (int ch = 0; ch < 4; ch++) begin
      checks++;
      if (exc0[ch*16 +: 16] !== 16'(exp_exc[ch]) || exc1[ch*16 +: 16] !== 16'(exp_exc[ch]))
        begin errors++; $display("FAIL wide_exc ch%0d got %h exp %h", ch, exc0[ch*16 +: 16], exp_exc[ch]); end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (al0 !== m_al[0] || al0 !== 4'b0111) begin errors++; $display("FAIL wide_alarm got %b exp 0111", al0); end
    set_dat(3, 700);
    repeat (2) pulse(4'b1000, 1'b0);
    @(negedge clk);
    dat_en = 4'b1000;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({exc0, exc1} !== '0 || {exc_en0, exc_en1, al0, al1, any0, any1} !== '0)
      begin errors++; $display("FAIL midrst got %b%b%b%b exp 0", al0, al1, any0, any1); end
    @(negedge clk);
    dat_en = '0;
    checks++;
    if (exc_en0 !== 4'h0 || exc0 !== '0) begin errors++; $display("FAIL midrst_hold got %b exp 0", exc_en0); end
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    pulse(4'b1000, 1'b0);
    @(negedge clk);
    checks++;
    if (al0 !== m_al[0] || al0[3] !== 1'b0) begin errors++; $display("FAIL post_rst_cnt got %b exp 0", al0[3]); end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    bit         wc;
    do_reset();
    dbn = 8'($urandom_range(0, 3));
    for (int it = 0; it < 80; it++) begin
      mask = 4'($urandom_range(1, 15));
      wc   = ($urandom_range(0, 7) == 0);
      for (int ch = 0; ch < 4; ch++) set_dat(ch, 1000 + $urandom_range(0, 280) - 140);
      pulse(mask, wc);
      for (int ch = 0; ch < 4; ch++) begin
        checks++;
        if (exc0[ch*16 +: 16] !== 16'(exp_exc[ch]))
          begin errors++; $display("FAIL rand_exc it%0d ch%0d got %0d exp %0d", it, ch, exc0[ch*16 +: 16], exp_exc[ch]); end
      end
      if (!wc) @(negedge clk);
      checks++;
      if (al0 !== m_al[0] || al1 !== m_al[1])
        begin errors++; $display("FAIL rand_alarm it%0d got %b/%b exp %b/%b", it, al0, al1, m_al[0], m_al[1]); end
      @(negedge clk);
      checks++;
      if (any0 !== (|m_al[0]) || any1 !== (|m_al[1]))
        begin errors++; $display("FAIL rand_any it%0d got %b%b exp %b%b", it, any0, any1, |m_al[0], |m_al[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_rise();
    test_below_base();
    test_release();
    test_no_alarm_break();
    test_latch();
    test_back_to_back();
    test_wide_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
